// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: drives load/nop of PC, IF/ID, ID/EX, EX/WB registers.
// Latency: control outputs combinational from state+inputs; counters/flags registered.
// Backpressure: memory wait freezes all stages; load-use inserts one bubble; branches flush.
module pipe_hazard_ctrl #(
    parameter int RA_W        = 3,
    parameter int FLUSH_CYC   = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            br_taken,
    input  logic            mem_req,
    input  logic            mem_ack,
    output logic            pc_load,
    output logic            ifid_load,
    output logic            ifid_nop,
    output logic            idex_load,
    output logic            idex_nop,
    output logic            exwb_load,
    output logic [15:0]     stall_cnt,
    output logic            mem_err
);

    typedef enum logic [1:0] {RUN, LU_HOLD, FLUSH, MEMWAIT} state_t;

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYC - 1);
    localparam logic [7:0] WAIT_MAX     = 8'(MEM_TIMEOUT);

    state_t      state, state_nxt;
    state_t      saved, saved_nxt;
    logic [1:0]  flush_cnt, flush_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic        err_set;
    logic        lu;
    logic        mem_stall;

    // Load-use hazard: a load in EX writes a register the ID instruction reads (r0 is never a hazard)
    always_comb begin
        lu = ex_valid & ex_is_load & id_valid & (ex_rd != '0) &
             ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
        mem_stall = mem_req & ~mem_ack;
    end

    // Next-state and stage controls; priority is memory wait > branch > load-use
    always_comb begin
        pc_load   = 1'b1;
        ifid_load = 1'b1;
        ifid_nop  = 1'b0;
        idex_load = 1'b1;
        idex_nop  = 1'b0;
        exwb_load = 1'b1;
        state_nxt = state;
        saved_nxt = saved;
        flush_nxt = flush_cnt;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;

        if (!RSTN) begin
            pc_load   = 1'b0;
            ifid_load = 1'b0;
            idex_load = 1'b0;
            exwb_load = 1'b0;
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
        end else begin
            case (state)
                RUN, LU_HOLD, FLUSH: begin
                    if (mem_stall) begin
                        // Freeze every stage; the flush counter is left untouched so FLUSH resumes intact
                        pc_load   = 1'b0;
                        ifid_load = 1'b0;
                        idex_load = 1'b0;
                        exwb_load = 1'b0;
                        saved_nxt = state;
                        wait_nxt  = 8'd1;
                        state_nxt = MEMWAIT;
                    end else if (br_taken) begin
                        ifid_nop = 1'b1;
                        idex_nop = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            flush_nxt = FLUSH_RELOAD;
                            state_nxt = FLUSH;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else if (state == FLUSH) begin
                        // ID holds a flushed bubble here, so load-use cannot apply
                        ifid_nop  = 1'b1;
                        flush_nxt = flush_cnt - 2'd1;
                        if (flush_cnt <= 2'd1)
                            state_nxt = RUN;
                    end else if (state == RUN && lu) begin
                        // LU_HOLD ignores the hazard, so exactly one bubble is inserted
                        pc_load   = 1'b0;
                        ifid_load = 1'b0;
                        idex_nop  = 1'b1;
                        state_nxt = LU_HOLD;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                MEMWAIT: begin
                    if (mem_ack) begin
                        state_nxt = saved;
                    end else if (wait_cnt >= WAIT_MAX) begin
                        // Forced release: advance anyway and leave a sticky debug flag
                        err_set   = 1'b1;
                        state_nxt = saved;
                    end else begin
                        pc_load   = 1'b0;
                        ifid_load = 1'b0;
                        idex_load = 1'b0;
                        exwb_load = 1'b0;
                        wait_nxt  = wait_cnt + 8'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State, counters and debug registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= RUN;
            saved     <= RUN;
            flush_cnt <= 2'd0;
            wait_cnt  <= 8'd0;
            stall_cnt <= 16'd0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            saved     <= saved_nxt;
            flush_cnt <= flush_nxt;
            wait_cnt  <= wait_nxt;
            if (!pc_load && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (err_set)
                mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: scoreboard of expected stage controls plus counter/flag checks.
// Latency: inputs driven 1ns after rising edge, controls compared on the falling edge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

    // control vector {pc_load, ifid_load, ifid_nop, idex_load, idex_nop, exwb_load}
    localparam logic [5:0] ADV = 6'b110101;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] RST = 6'b001010;
    localparam logic [5:0] BRN = 6'b111111;
    localparam logic [5:0] LUS = 6'b000111;
    localparam logic [5:0] FLS = 6'b111101;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        id_valid, id_uses_rs, id_uses_rt, ex_valid, ex_is_load;
    logic [2:0]  id_rs, id_rt, ex_rd;
    logic        br_taken, mem_req, mem_ack;
    logic        pc_load, ifid_load, ifid_nop, idex_load, idex_nop, exwb_load;
    logic [15:0] stall_cnt;
    logic        mem_err;
    logic        pc_load_b, ifid_load_b, ifid_nop_b, idex_load_b, idex_nop_b, exwb_load_b;
    logic [15:0] stall_cnt_b;
    logic        mem_err_b;

    int          n_chk = 0;
    int          n_err = 0;
    logic [5:0]  exp_q[$];
    string       tag_q[$];
    logic [5:0]  mon_exp;
    string       mon_tag;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.RA_W(3), .FLUSH_CYC(2), .MEM_TIMEOUT(15)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_load(pc_load), .ifid_load(ifid_load), .ifid_nop(ifid_nop),
        .idex_load(idex_load), .idex_nop(idex_nop), .exwb_load(exwb_load),
        .stall_cnt(stall_cnt), .mem_err(mem_err)
    );

    // Second instance with a long timeout, used for the stall counter saturation run
    pipe_hazard_ctrl #(.RA_W(3), .FLUSH_CYC(1), .MEM_TIMEOUT(255)) dut_b (
        .CLK(CLK), .RSTN(RSTN),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_load(pc_load_b), .ifid_load(ifid_load_b), .ifid_nop(ifid_nop_b),
        .idex_load(idex_load_b), .idex_nop(idex_nop_b), .exwb_load(exwb_load_b),
        .stall_cnt(stall_cnt_b), .mem_err(mem_err_b)
    );

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: compare the combinational controls mid-cycle
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            chk_val(mon_tag, {26'd0, pc_load, ifid_load, ifid_nop, idex_load, idex_nop, exwb_load},
                    {26'd0, mon_exp});
        end
    end

    task automatic idle();
        id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; ex_valid = 0; ex_is_load = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0; br_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic set_lu(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                          input logic urs, input logic urt);
        id_valid = 1; ex_valid = 1; ex_is_load = 1;
        id_rs = rs; id_rt = rt; ex_rd = rd; id_uses_rs = urs; id_uses_rt = urt;
    endtask

    // Push the expected controls for the current inputs, then move past the next rising edge
    task automatic cyc(input logic [5:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RSTN = 0;
        br_taken = 1;
        @(posedge CLK);
        #1;
        cyc(RST, "rst_c0");
        cyc(RST, "rst_c1");
        chk_val("rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk_val("rst_err", {31'd0, mem_err}, 32'd0);

        RSTN = 1; idle();
        cyc(ADV, "idle_0");
        cyc(ADV, "idle_1");
        chk_val("idle_stall", {16'd0, stall_cnt}, 32'd0);

        // load-use on rs held two cycles: one bubble only
        set_lu(3'd3, 3'd0, 3'd3, 1, 0);
        cyc(LUS, "lu_rs_c0");
        cyc(ADV, "lu_rs_c1");
        idle();
        cyc(ADV, "lu_rs_after");
        chk_val("lu_stall", {16'd0, stall_cnt}, 32'd1);

        set_lu(3'd1, 3'd5, 3'd5, 0, 1);
        cyc(LUS, "lu_rt_c0");
        idle();
        cyc(ADV, "lu_rt_c1");
        set_lu(3'd0, 3'd0, 3'd0, 1, 1);
        cyc(ADV, "lu_rd0");
        set_lu(3'd4, 3'd0, 3'd4, 0, 0);
        cyc(ADV, "lu_unused");
        idle();
        chk_val("lu_rt_stall", {16'd0, stall_cnt}, 32'd2);

        // branch with two flush cycles
        br_taken = 1;
        cyc(BRN, "br_c0");
        idle();
        cyc(FLS, "br_c1");
        cyc(ADV, "br_c2");

        // branch and load-use together: branch wins
        set_lu(3'd2, 3'd0, 3'd2, 1, 0);
        br_taken = 1;
        cyc(BRN, "br_lu_c0");
        idle();
        cyc(FLS, "br_lu_c1");
        cyc(ADV, "br_lu_c2");
        chk_val("br_lu_stall", {16'd0, stall_cnt}, 32'd2);

        // branch taken again while flushing reloads the flush count
        br_taken = 1;
        cyc(BRN, "br2_c0");
        cyc(BRN, "br2_c1");
        idle();
        cyc(FLS, "br2_c2");
        cyc(ADV, "br2_c3");

        // memory wait: ack on the 4th cycle
        mem_req = 1;
        cyc(FRZ, "mw_c0");
        cyc(FRZ, "mw_c1");
        cyc(FRZ, "mw_c2");
        mem_ack = 1;
        cyc(ADV, "mw_ack");
        idle();
        cyc(ADV, "mw_after");
        chk_val("mw_stall", {16'd0, stall_cnt}, 32'd5);

        // memory wait in the middle of a flush: flush resumes with its remaining count
        br_taken = 1;
        cyc(BRN, "mwf_br");
        idle(); mem_req = 1;
        cyc(FRZ, "mwf_c0");
        cyc(FRZ, "mwf_c1");
        mem_ack = 1;
        cyc(ADV, "mwf_ack");
        idle();
        cyc(FLS, "mwf_resume");
        cyc(ADV, "mwf_done");
        chk_val("mwf_stall", {16'd0, stall_cnt}, 32'd7);

        // same-cycle req and ack: no wait, branch handled normally
        mem_req = 1; mem_ack = 1; br_taken = 1;
        cyc(BRN, "reqack_br");
        idle();
        cyc(FLS, "reqack_fl");
        cyc(ADV, "reqack_adv");

        // branch and hazard ignored while waiting on memory
        mem_req = 1;
        cyc(FRZ, "mwi_c0");
        idle(); set_lu(3'd6, 3'd0, 3'd6, 1, 0); br_taken = 1;
        cyc(FRZ, "mwi_c1");
        br_taken = 0; mem_ack = 1; mem_req = 1;
        cyc(ADV, "mwi_ack");
        mem_req = 0; mem_ack = 0;
        cyc(LUS, "mwi_lu");
        idle();
        cyc(ADV, "mwi_after");
        chk_val("mwi_stall", {16'd0, stall_cnt}, 32'd10);

        // timeout: 15 frozen cycles, forced advance, sticky error
        mem_req = 1;
        for (int i = 0; i < 15; i++) cyc(FRZ, $sformatf("to_frz%0d", i));
        chk_val("to_err_pre", {31'd0, mem_err}, 32'd0);
        cyc(ADV, "to_release");
        chk_val("to_err_set", {31'd0, mem_err}, 32'd1);
        idle();
        cyc(ADV, "to_after");
        cyc(ADV, "to_after2");
        chk_val("to_err_sticky", {31'd0, mem_err}, 32'd1);
        chk_val("to_stall", {16'd0, stall_cnt}, 32'd25);

        // reset clears the sticky flag and counter
        RSTN = 0;
        cyc(RST, "rst2");
        chk_val("rst2_err", {31'd0, mem_err}, 32'd0);
        chk_val("rst2_stall", {16'd0, stall_cnt}, 32'd0);
        RSTN = 1;
        cyc(ADV, "rst2_rel");

        // saturation: 255 stalled cycles per 256 on the long-timeout instance
        RSTN = 0;
        @(posedge CLK); #1;
        RSTN = 1; mem_req = 1;
        repeat (66000) @(posedge CLK);
        #1;
        chk_val("sat_reach", {16'd0, stall_cnt_b}, 32'h0000FFFF);
        repeat (600) @(posedge CLK);
        #1;
        chk_val("sat_hold", {16'd0, stall_cnt_b}, 32'h0000FFFF);
        chk_val("sat_err", {31'd0, mem_err_b}, 32'd1);
        chk_val("sb_drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
